tx_serial: RTL and testbench

TX_SERIAL -- requirements
Module: tx_serial

---
 rtl/tx_serial.sv | 168 ++++++++++++++++
 tb/tb_tx_serial.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serial.sv
// Serial byte transmitter: start bit, MSB-first data, optional parity, 1 or 2 stop bits, CTS/RTS handshake.
// Define TX_HOLD_EN to add a one-byte hold register so frames can be sent back to back.
module tx_serial #(
    parameter logic [7:0] MODOS_DE_OPERACAO = 8'b10110101
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [7:0] DATA_IN,
    input  logic       LOAD,
    input  logic       CTS,
    output logic       DATA_OUT,
    output logic       RTS,
    output logic       READY,
    output logic       DONE
);
    localparam logic [15:0] DIV =
        (MODOS_DE_OPERACAO[7:6] == 2'b00) ? 16'd10416 :
        (MODOS_DE_OPERACAO[7:6] == 2'b01) ? 16'd5208  :
        (MODOS_DE_OPERACAO[7:6] == 2'b10) ? 16'd2604  : 16'd868;
    localparam logic TWO_STOP = !MODOS_DE_OPERACAO[5];
    localparam logic PAR_ODD  = MODOS_DE_OPERACAO[1];
    localparam logic PAR_EN   = MODOS_DE_OPERACAO[0];

    typedef enum logic [2:0] {
        IDLE, WAIT_CTS, START, DATA, PARITY, STOP1, STOP2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        dout_q, dout_d;
    logic        in_bit, bit_end, frame_end, accept;

`ifdef TX_HOLD_EN
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;

    assign READY = !hold_valid_q;
    assign RTS   = (state_q != IDLE) || hold_valid_q;
`else
    assign READY = (state_q == IDLE);
    assign RTS   = (state_q != IDLE);
`endif

    assign accept    = LOAD && READY;
    assign in_bit    = (state_q != IDLE) && (state_q != WAIT_CTS);
    assign bit_end   = in_bit && (cnt_q == DIV);
    // The last stop bit depends on the stop-bit select; DONE is its final clock.
    assign frame_end = bit_end && ((state_q == STOP2) || ((state_q == STOP1) && !TWO_STOP));
    assign DONE      = frame_end;
    assign DATA_OUT  = dout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = in_bit ? (bit_end ? 16'd0 : cnt_q + 16'd1) : 16'd0;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
`ifdef TX_HOLD_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT_CTS;
                    shift_d = DATA_IN;
                    par_d   = (^DATA_IN) ^ PAR_ODD;
                end
            end
            WAIT_CTS: begin
                if (CTS) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd7;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd0) begin
                        state_d = PAR_EN ? PARITY : STOP1;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    state_d = TWO_STOP ? STOP2 : IDLE;
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef TX_HOLD_EN
        // A held byte (or one loaded on the DONE cycle) chains straight into the next frame.
        if (frame_end) begin
            if (hold_valid_q) begin
                state_d      = WAIT_CTS;
                shift_d      = hold_q;
                par_d        = (^hold_q) ^ PAR_ODD;
                hold_valid_d = 1'b0;
            end else if (accept) begin
                state_d = WAIT_CTS;
                shift_d = DATA_IN;
                par_d   = (^DATA_IN) ^ PAR_ODD;
            end
        end else if (accept && (state_q != IDLE)) begin
            hold_d       = DATA_IN;
            hold_valid_d = 1'b1;
        end
`endif

        case (state_d)
            START:   dout_d = 1'b0;
            DATA:    dout_d = shift_d[idx_d];
            PARITY:  dout_d = par_d;
            default: dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
        end
    end

`ifdef TX_HOLD_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_tx_serial.sv
// Scoreboard bench for tx_serial: three lanes with different frame modes run in parallel;
// stimulus queues hand-computed frames, a per-lane monitor decodes the serial line and checks them.
module tb_tx_serial;
    localparam int NL = 3;
    localparam logic [7:0] MODE [NL] = '{8'b10110101, 8'b11000011, 8'b11000000};

    typedef struct {
        logic [15:0] bits;   // leftmost of the n used bits is the first bit on the line
        int          n;
        logic [7:0]  b;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n [NL];
    logic [7:0] din   [NL];
    logic       load  [NL];
    logic       cts   [NL];
    logic       dout  [NL];
    logic       rts   [NL];
    logic       ready [NL];
    logic       done  [NL];

    int errors = 0;
    int checks = 0;
    frame_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        tx_serial #(.MODOS_DE_OPERACAO(MODE[gi])) u_dut (
            .Clock   (clk),
            .Reset_n (rst_n[gi]),
            .DATA_IN (din[gi]),
            .LOAD    (load[gi]),
            .CTS     (cts[gi]),
            .DATA_OUT(dout[gi]),
            .RTS     (rts[gi]),
            .READY   (ready[gi]),
            .DONE    (done[gi])
        );
    end

    // Bit period in clocks for each lane's mode (baud select 10 -> 2605, 11 -> 869).
    function automatic int period(input int ln);
        return (ln == 0) ? 2605 : 869;
    endfunction

    function automatic void push_frame(input int ln, input logic [15:0] bits, input int n, input logic [7:0] b);
        frame_t f;
        f.bits = bits; f.n = n; f.b = b;
        case (ln)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endfunction

    function automatic bit pop_frame(input int ln, output frame_t f);
        bit ok;
        ok = 1'b0;
        f = '{16'h0, 0, 8'h0};
        case (ln)
            0:       if (q0.size() > 0) begin f = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin f = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin f = q2.pop_front(); ok = 1'b1; end
        endcase
        return ok;
    endfunction

    function automatic int q_size(input int ln);
        case (ln)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int ln, input logic [7:0] b);
        din[ln]  = b;
        load[ln] = 1'b1;
        @(negedge clk);
        load[ln] = 1'b0;
    endtask

    task automatic wait_done(input int ln, input int budget, input string name);
        int k;
        k = 0;
        while (done[ln] !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, done[ln], 1);
    endtask

    task automatic quiet(input int ln, input int n, input string name);
        int bad;
        bad = 0;
        repeat (n) begin
            if (dout[ln] !== 1'b1 || done[ln] !== 1'b0 || ready[ln] !== 1'b1 || rts[ln] !== 1'b0) bad++;
            @(negedge clk);
        end
        check(name, bad, 0);
    endtask

    task automatic monitor(input int ln);
        frame_t f;
        int per, c, last, done_at, bad_at, skip;
        logic exp_bit, bad_got;
        bit busy;
        per = period(ln);
        busy = 1'b0; c = 0; last = 0; done_at = -1; bad_at = -1; skip = 0; bad_got = 1'b0;
        f = '{16'h0, 0, 8'h0};
        forever begin
            @(negedge clk);
            if (rst_n[ln] !== 1'b1) begin
                if (busy) $display("lane%0d frame 0x%02h cut short by reset at cycle %0d", ln, f.b, c);
                busy = 1'b0;
                skip = 0;
            end else if (skip > 0) begin
                skip--;
            end else begin
                if (!busy) begin
                    if (done[ln] === 1'b1) begin
                        checks++; errors++;
                        $display("FAIL lane%0d done_idle: DONE=1 outside a frame, want 0", ln);
                    end
                    if (dout[ln] === 1'b0) begin
                        checks++;
                        if (pop_frame(ln, f)) begin
                            busy = 1'b1; c = 0; last = f.n * per - 1; done_at = -1; bad_at = -1;
                        end else begin
                            errors++;
                            $display("FAIL lane%0d stray_frame: start bit seen with no frame queued, want idle line", ln);
                            skip = 12 * per;
                        end
                    end
                end
                if (busy) begin
                    exp_bit = f.bits[f.n - 1 - c / per];
                    if (dout[ln] !== exp_bit && bad_at < 0) begin
                        bad_at  = c;
                        bad_got = dout[ln];
                    end
                    if (done[ln] === 1'b1 && done_at < 0) done_at = c;
                    if (c == last) begin
                        checks += 2;
                        if (bad_at >= 0) begin
                            errors++;
                            $display("FAIL lane%0d frame_bits 0x%02h: cycle %0d (bit %0d) got %b want %b",
                                     ln, f.b, bad_at, bad_at / per, bad_got, f.bits[f.n - 1 - bad_at / per]);
                        end
                        if (done_at != last) begin
                            errors++;
                            $display("FAIL lane%0d done_timing 0x%02h: DONE first at cycle %0d want %0d",
                                     ln, f.b, done_at, last);
                        end
                        if (bad_at < 0 && done_at == last)
                            $display("lane%0d frame 0x%02h: %0d bits x %0d clocks, DONE at cycle %0d",
                                     ln, f.b, f.n, per, done_at);
                        busy = 1'b0;
                    end
                    c++;
                end
            end
        end
    endtask

    // Default mode: even parity, one stop bit, 2605-clock bits.
    task automatic run_lane0();
        push_frame(0, 16'(11'b0_10100101_0_1), 11, 8'hA5);
        do_load(0, 8'hA5);
        tick(5000);
        check("lane0 rts_busy", rts[0], 1);
`ifdef TX_HOLD_EN
        check("lane0 ready_busy", ready[0], 1);
`else
        check("lane0 ready_busy", ready[0], 0);
`endif
        wait_done(0, 30000, "lane0 done_A5");
        tick(1);
        check("lane0 ready_after", ready[0], 1);
        check("lane0 rts_after", rts[0], 0);
    endtask

    // Odd parity, two stop bits: parity values, CTS gating, reset mid-frame.
    task automatic run_lane1();
        int bad;
        push_frame(1, 16'(12'b0_00000111_0_11), 12, 8'h07);
        do_load(1, 8'h07);
        tick(20);
        wait_done(1, 15000, "lane1 done_07");
        tick(2);
        push_frame(1, 16'(12'b0_00000011_1_11), 12, 8'h03);
        do_load(1, 8'h03);
        tick(20);
        wait_done(1, 15000, "lane1 done_03");
        tick(2);

        cts[1] = 1'b0;
        push_frame(1, 16'(12'b0_00111100_1_11), 12, 8'h3C);
        do_load(1, 8'h3C);
        bad = 0;
        repeat (500) begin
            if (dout[1] !== 1'b1 || rts[1] !== 1'b1) bad++;
            @(negedge clk);
        end
        check("lane1 cts_wait_line_high_rts", bad, 0);
        cts[1] = 1'b1;
        tick(1);
        check("lane1 start_after_cts", dout[1], 0);
        tick(1000);
        cts[1] = 1'b0;
        wait_done(1, 15000, "lane1 done_3C_cts_dropped");
        cts[1] = 1'b1;
        tick(2);

        push_frame(1, 16'(12'b0_11110000_1_11), 12, 8'hF0);
        do_load(1, 8'hF0);
        bad = 0;
        while (dout[1] !== 1'b0 && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        check("lane1 F0_started", dout[1], 0);
        tick(5 * 869 + 400);
        rst_n[1] = 1'b0;
        #1;
        check("lane1 rst_dout", dout[1], 1);
        check("lane1 rst_rts", rts[1], 0);
        check("lane1 rst_ready", ready[1], 1);
        check("lane1 rst_done", done[1], 0);
        @(negedge clk);
        tick(2);
        rst_n[1] = 1'b1;
        quiet(1, 7000, "lane1 after_reset_quiet");
    endtask

    // No parity, two stop bits: LOAD on the DONE cycle and LOAD mid-frame.
    task automatic run_lane2();
        push_frame(2, 16'(11'b0_00000000_11), 11, 8'h00);
        do_load(2, 8'h00);
        tick(20);
        wait_done(2, 12000, "lane2 done_00");
`ifdef TX_HOLD_EN
        check("lane2 ready_on_done", ready[2], 1);
        push_frame(2, 16'(11'b0_10000001_11), 11, 8'h81);
`else
        check("lane2 ready_on_done", ready[2], 0);
`endif
        do_load(2, 8'h81);
`ifdef TX_HOLD_EN
        tick(20);
        wait_done(2, 12000, "lane2 done_81");
        tick(2);
`else
        quiet(2, 1500, "lane2 load_on_done_dropped");
`endif

        push_frame(2, 16'(11'b0_01010101_11), 11, 8'h55);
        do_load(2, 8'h55);
        tick(3000);
`ifdef TX_HOLD_EN
        push_frame(2, 16'(11'b0_10101010_11), 11, 8'hAA);
`endif
        do_load(2, 8'hAA);
        check("lane2 ready_after_second_load", ready[2], 0);
        wait_done(2, 12000, "lane2 done_55");
        check("lane2 ready_on_done_55", ready[2], 0);
        tick(2);
`ifdef TX_HOLD_EN
        check("lane2 back_to_back_start", dout[2], 0);
        tick(20);
        wait_done(2, 12000, "lane2 done_AA");
        tick(2);
`else
        check("lane2 back_to_back_start", dout[2], 1);
        quiet(2, 1500, "lane2 mid_frame_load_dropped");
`endif
    endtask

    initial begin
        repeat (95000) @(negedge clk);
        $display("FAIL watchdog: bench still running after 95000 cycles, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NL; i++) begin
            rst_n[i] = 1'b0;
            din[i]   = 8'h00;
            load[i]  = 1'b0;
            cts[i]   = 1'b1;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        tick(3);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("lane%0d reset_dout", i), dout[i], 1);
            check($sformatf("lane%0d reset_rts", i), rts[i], 0);
            check($sformatf("lane%0d reset_ready", i), ready[i], 1);
            check($sformatf("lane%0d reset_done", i), done[i], 0);
        end
        for (int i = 0; i < NL; i++) rst_n[i] = 1'b1;
        tick(1);
        fork
            run_lane0();
            run_lane1();
            run_lane2();
        join
        tick(5);
        for (int i = 0; i < NL; i++)
            check($sformatf("lane%0d frames_outstanding", i), q_size(i), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
